// File: rtl/dram_pkg.sv
// Shared types and default parameters for the block-transfer DRAM model.
package dram_pkg;

    localparam int unsigned WORD_W      = 32;
    localparam int unsigned DEF_WORDS   = 4;
    localparam int unsigned DEF_ADDR_W  = 20;
    localparam int unsigned DEF_LATENCY = 1;

    typedef enum logic {
        IDLE,
        WAIT
    } state_t;

endpackage

// File: rtl/dram_array.sv
// Word-addressed storage with a block-wide synchronous write port and a
// block-wide registered read port sharing one block base address.
module dram_array
    import dram_pkg::*;
#(
    parameter int unsigned WORDS  = DEF_WORDS,
    parameter int unsigned ADDR_W = DEF_ADDR_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_we,
    input  logic                     i_re,
    input  logic [ADDR_W-1:0]        i_base,
    input  logic [WORD_W*WORDS-1:0]  i_wdata,
    output logic [WORD_W*WORDS-1:0]  o_rdata
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    // Zero contents at time zero; reset never touches the array.
    logic [WORD_W-1:0]        r_mem [DEPTH] = '{default: '0};
    logic [WORD_W*WORDS-1:0]  r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int k = 0; k < WORDS; k++) begin
                r_mem[i_base + ADDR_W'(k)] <= i_wdata[WORD_W*k +: WORD_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rdata <= '0;
        end else if (i_re) begin
            for (int k = 0; k < WORDS; k++) begin
                r_rdata[WORD_W*k +: WORD_W] <= r_mem[i_base + ADDR_W'(k)];
            end
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/dram_block_mem.sv
// Fixed-latency block memory: accepts one block read or write at a time,
// completes it LATENCY cycles after acceptance and pulses Ready.
module dram_block_mem
    import dram_pkg::*;
#(
    parameter int unsigned WORDS   = DEF_WORDS,
    parameter int unsigned ADDR_W  = DEF_ADDR_W,
    parameter int unsigned LATENCY = DEF_LATENCY
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     Valid,
    input  logic                     MemWrite,
    input  logic [31:0]              DataAdr,
    input  logic [WORD_W*WORDS-1:0]  WriteDataBlock,
    output logic [WORD_W*WORDS-1:0]  ReadDataBlock,
    output logic                     Ready,
    output logic                     Busy
);

    localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    state_t                   r_state;
    logic [CNT_W-1:0]         r_cnt;
    logic                     r_write;
    logic [ADDR_W-1:0]        r_base;
    logic [WORD_W*WORDS-1:0]  r_wdata;
    logic                     r_ready;
    logic                     r_busy;

    logic [ADDR_W-1:0]        w_base;
    logic                     w_done;
    logic                     w_unused_adr;

    // Upper address bits are dropped so accesses wrap modulo the depth.
    assign w_base       = DataAdr[ADDR_W-1:0] & ~ADDR_W'(WORDS - 1);
    assign w_unused_adr = ^DataAdr;
    assign w_done       = (r_state == WAIT) && (r_cnt == '0) && !reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_ready <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_ready <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (Valid) begin
                        r_write <= MemWrite;
                        r_base  <= w_base;
                        r_wdata <= WriteDataBlock;
                        r_cnt   <= CNT_W'(LATENCY - 1);
                        r_busy  <= 1'b1;
                        r_state <= WAIT;
                    end
                end
                WAIT: begin
                    if (r_cnt == '0) begin
                        r_ready <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    dram_array #(
        .WORDS  (WORDS),
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk     (clk),
        .reset   (reset),
        .i_we    (w_done && r_write),
        .i_re    (w_done && !r_write),
        .i_base  (r_base),
        .i_wdata (r_wdata),
        .o_rdata (ReadDataBlock)
    );

    assign Ready = r_ready;
    assign Busy  = r_busy;

endmodule

// File: tb/tb_dram_block_mem.sv
// Directed bench: three instances (LATENCY 1, 5 and 4) checked cycle by cycle.
module tb_dram_block_mem;

    logic                clk = 1'b0;
    logic                reset = 1'b0;
    logic [2:0]          v_valid = '0;
    logic [2:0]          v_we = '0;
    logic [2:0][31:0]    v_adr = '0;
    logic [2:0][127:0]   v_wdata = '0;
    logic [2:0][127:0]   v_rdata;
    logic [2:0]          v_ready;
    logic [2:0]          v_busy;

    int n_cmp = 0;
    int n_bad = 0;

    localparam logic [127:0] BLK0 = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
    localparam logic [127:0] D1   = 128'hA4A4A4A4_A3A3A3A3_A2A2A2A2_A1A1A1A1;
    localparam logic [127:0] D2   = 128'hCAFE0003_CAFE0002_CAFE0001_CAFE0000;
    localparam logic [127:0] P0   = 128'h50505050_60606060_70707070_80808080;
    localparam logic [127:0] Q0   = 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF;

    always #5 clk = ~clk;

    dram_block_mem u_a (
        .clk(clk), .reset(reset), .Valid(v_valid[0]), .MemWrite(v_we[0]), .DataAdr(v_adr[0]),
        .WriteDataBlock(v_wdata[0]), .ReadDataBlock(v_rdata[0]), .Ready(v_ready[0]),
        .Busy(v_busy[0])
    );

    dram_block_mem #(.WORDS(4), .ADDR_W(8), .LATENCY(5)) u_b (
        .clk(clk), .reset(reset), .Valid(v_valid[1]), .MemWrite(v_we[1]), .DataAdr(v_adr[1]),
        .WriteDataBlock(v_wdata[1]), .ReadDataBlock(v_rdata[1]), .Ready(v_ready[1]),
        .Busy(v_busy[1])
    );

    dram_block_mem #(.WORDS(4), .ADDR_W(8), .LATENCY(4)) u_c (
        .clk(clk), .reset(reset), .Valid(v_valid[2]), .MemWrite(v_we[2]), .DataAdr(v_adr[2]),
        .WriteDataBlock(v_wdata[2]), .ReadDataBlock(v_rdata[2]), .Ready(v_ready[2]),
        .Busy(v_busy[2])
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues one request; lat = edges from acceptance to Ready, 0 on timeout.
    task automatic do_req(input int i, input logic we, input logic [31:0] adr,
                          input logic [127:0] wd, output int lat);
        v_valid[i] = 1'b1;
        v_we[i]    = we;
        v_adr[i]   = adr;
        v_wdata[i] = wd;
        tick();
        v_valid[i] = 1'b0;
        lat = 0;
        for (int n = 1; n <= 12; n++) begin
            tick();
            if (v_ready[i] === 1'b1) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if (v_ready[i] !== 1'b0) begin
                n_bad++; $display("FAIL reset_ready[%0d] got %b want 0", i, v_ready[i]);
            end
            n_cmp++;
            if (v_busy[i] !== 1'b0) begin
                n_bad++; $display("FAIL reset_busy[%0d] got %b want 0", i, v_busy[i]);
            end
            n_cmp++;
            if (v_rdata[i] !== 128'h0) begin
                n_bad++; $display("FAIL reset_rdata[%0d] got %h want 0", i, v_rdata[i]);
            end
        end
    endtask

    task automatic test_basic_rw();
        int lat;
        v_valid[0] = 1'b1; v_we[0] = 1'b1; v_adr[0] = 32'h100; v_wdata[0] = BLK0;
        tick();
        v_valid[0] = 1'b0;
        n_cmp++;
        if (v_busy[0] !== 1'b1 || v_ready[0] !== 1'b0) begin
            n_bad++; $display("FAIL basic_accept busy/ready got %b/%b want 1/0", v_busy[0], v_ready[0]);
        end
        tick();
        n_cmp++;
        if (v_busy[0] !== 1'b0 || v_ready[0] !== 1'b1) begin
            n_bad++; $display("FAIL basic_done busy/ready got %b/%b want 0/1", v_busy[0], v_ready[0]);
        end
        tick();
        n_cmp++;
        if (v_ready[0] !== 1'b0) begin
            n_bad++; $display("FAIL basic_ready_pulse got %b want 0", v_ready[0]);
        end
        do_req(0, 1'b0, 32'h100, '0, lat);
        n_cmp++;
        if (lat !== 1) begin
            n_bad++; $display("FAIL basic_read_latency got %0d want 1", lat);
        end
        n_cmp++;
        if (v_rdata[0] !== BLK0) begin
            n_bad++; $display("FAIL basic_read_data got %h want %h", v_rdata[0], BLK0);
        end
    endtask

    task automatic test_misaligned();
        int lat;
        do_req(0, 1'b1, 32'h103, D1, lat);
        do_req(0, 1'b0, 32'h100, '0, lat);
        n_cmp++;
        if (v_rdata[0] !== D1) begin
            n_bad++; $display("FAIL misaligned_block got %h want %h", v_rdata[0], D1);
        end
        do_req(0, 1'b0, 32'h104, '0, lat);
        n_cmp++;
        if (v_rdata[0] !== 128'h0) begin
            n_bad++; $display("FAIL misaligned_neighbour got %h want 0", v_rdata[0]);
        end
    endtask

    task automatic test_wrap();
        int lat;
        do_req(0, 1'b1, 32'h0010_0100, D2, lat);
        n_cmp++;
        if (v_rdata[0] !== 128'h0) begin
            n_bad++; $display("FAIL hold_after_write got %h want 0", v_rdata[0]);
        end
        do_req(0, 1'b0, 32'h0000_0100, '0, lat);
        n_cmp++;
        if (v_rdata[0] !== D2) begin
            n_bad++; $display("FAIL wrap_read got %h want %h", v_rdata[0], D2);
        end
    endtask

    task automatic test_latency5();
        int lat;
        logic exp_busy, exp_ready;
        v_valid[1] = 1'b1; v_we[1] = 1'b0; v_adr[1] = 32'h10; v_wdata[1] = '0;
        tick();
        for (int k = 0; k <= 6; k++) begin
            if (k > 0) begin
                v_valid[1] = (k <= 4) ? k[0] : 1'b0;
                v_we[1]    = 1'b1;
                v_adr[1]   = 32'h20;
                v_wdata[1] = {128{1'b1}};
                tick();
            end
            exp_busy  = (k < 5);
            exp_ready = (k == 5);
            n_cmp++;
            if (v_busy[1] !== exp_busy || v_ready[1] !== exp_ready) begin
                n_bad++;
                $display("FAIL lat5_edge%0d busy/ready got %b/%b want %b/%b",
                         k, v_busy[1], v_ready[1], exp_busy, exp_ready);
            end
        end
        v_valid[1] = 1'b0;
        do_req(1, 1'b0, 32'h20, '0, lat);
        n_cmp++;
        if (lat !== 5) begin
            n_bad++; $display("FAIL lat5_read_latency got %0d want 5", lat);
        end
        n_cmp++;
        if (v_rdata[1] !== 128'h0) begin
            n_bad++; $display("FAIL lat5_ignored_valid got %h want 0", v_rdata[1]);
        end
    endtask

    task automatic test_back_to_back();
        int t;
        int n_rdy;
        int lat;
        int times [8];
        n_rdy = 0;
        v_valid[1] = 1'b1; v_we[1] = 1'b1; v_adr[1] = 32'h0;
        v_wdata[1] = {4{32'hB2B00000}};
        tick();
        for (t = 1; t <= 60; t++) begin
            tick();
            if (v_ready[1] === 1'b1) begin
                if (n_rdy < 8) times[n_rdy] = t;
                n_rdy++;
                if (n_rdy < 8) begin
                    v_adr[1]   = 32'(n_rdy * 4);
                    v_wdata[1] = {4{32'hB2B00000 + 32'(n_rdy)}};
                end else begin
                    v_valid[1] = 1'b0;
                end
            end
        end
        v_valid[1] = 1'b0;
        n_cmp++;
        if (n_rdy !== 8) begin
            n_bad++; $display("FAIL b2b_count got %0d want 8", n_rdy);
        end
        for (int i = 0; i < 8 && i < n_rdy; i++) begin
            n_cmp++;
            if (times[i] !== 5 + 6 * i) begin
                n_bad++; $display("FAIL b2b_ready_time[%0d] got %0d want %0d", i, times[i], 5 + 6 * i);
            end
        end
        do_req(1, 1'b0, 32'd28, '0, lat);
        n_cmp++;
        if (v_rdata[1] !== {4{32'hB2B00007}}) begin
            n_bad++; $display("FAIL b2b_block7 got %h want %h", v_rdata[1], {4{32'hB2B00007}});
        end
        do_req(1, 1'b0, 32'd0, '0, lat);
        n_cmp++;
        if (v_rdata[1] !== {4{32'hB2B00000}}) begin
            n_bad++; $display("FAIL b2b_block0 got %h want %h", v_rdata[1], {4{32'hB2B00000}});
        end
    endtask

    task automatic test_reset_abort();
        int lat;
        int n_pulse;
        do_req(2, 1'b1, 32'h40, P0, lat);
        n_cmp++;
        if (lat !== 4) begin
            n_bad++; $display("FAIL abort_prewrite_latency got %0d want 4", lat);
        end
        v_valid[2] = 1'b1; v_we[2] = 1'b1; v_adr[2] = 32'h40; v_wdata[2] = Q0;
        tick();
        v_valid[2] = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_cmp++;
        if (v_busy[2] !== 1'b0 || v_ready[2] !== 1'b0) begin
            n_bad++; $display("FAIL abort_state busy/ready got %b/%b want 0/0", v_busy[2], v_ready[2]);
        end
        n_pulse = 0;
        for (int n = 0; n < 8; n++) begin
            tick();
            if (v_ready[2] !== 1'b0) n_pulse++;
        end
        n_cmp++;
        if (n_pulse !== 0) begin
            n_bad++; $display("FAIL abort_no_ready got %0d pulses want 0", n_pulse);
        end
        do_req(2, 1'b0, 32'h40, '0, lat);
        n_cmp++;
        if (v_rdata[2] !== P0) begin
            n_bad++; $display("FAIL abort_prior_contents got %h want %h", v_rdata[2], P0);
        end
        n_cmp++;
        if (v_rdata[0] !== 128'h0) begin
            n_bad++; $display("FAIL reset_clears_rdata got %h want 0", v_rdata[0]);
        end
        do_req(0, 1'b0, 32'h100, '0, lat);
        n_cmp++;
        if (v_rdata[0] !== D2) begin
            n_bad++; $display("FAIL reset_keeps_storage got %h want %h", v_rdata[0], D2);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic_rw();
        test_misaligned();
        test_wrap();
        test_latency5();
        test_back_to_back();
        test_reset_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dram_block_mem.md
DRAM_BLOCK_MEM -- requirements
Module: dram_block_mem

Interface
REQ-001 The block SHALL have parameter WORDS, default 4, meaning 32-bit words per block; it SHALL be a power of two and at least 1.
REQ-002 The block SHALL have parameter ADDR_W, default 20, meaning the word-address width; storage depth SHALL be 2**ADDR_W words.
REQ-003 The block SHALL have parameter LATENCY, default 1, meaning cycles from request acceptance to Ready; it SHALL be at least 1.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic SHALL be on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port Valid, input, 1 bit: request strobe.
REQ-007 The block SHALL have port MemWrite, input, 1 bit: 1 = block write, 0 = block read.
REQ-008 The block SHALL have port DataAdr, input, 32 bits: word address.
REQ-009 The block SHALL have port WriteDataBlock, input, 32*WORDS bits: write block, with word k in bits [32k+31:32k].
REQ-010 The block SHALL have port ReadDataBlock, output, 32*WORDS bits: read block, in the same word order as WriteDataBlock.
REQ-011 The block SHALL have port Ready, output, 1 bit: one-cycle completion pulse.
REQ-012 The block SHALL have port Busy, output, 1 bit: high while a request is in flight.

Function
REQ-013 The block SHALL implement FSM states IDLE and WAIT; it SHALL leave reset in IDLE.
REQ-014 In IDLE, with Valid=1, the block SHALL accept the request at that edge, latch MemWrite, the base address and WriteDataBlock, go to WAIT, load the counter with LATENCY-1, and drive Busy=1 from the next cycle.
REQ-015 The base address SHALL be DataAdr[ADDR_W-1:0] with its low log2(WORDS) bits forced to 0 (block-aligned); DataAdr bits at ADDR_W and above SHALL be ignored, giving wrap modulo depth.
REQ-016 In WAIT, the counter SHALL decrement each cycle; the completion edge SHALL be the one at which the counter equals 0.
REQ-017 At the completion edge of a write, the block SHALL store latched word k at base+k for all k; at the completion edge of a read, it SHALL load ReadDataBlock word k from base+k.
REQ-018 At the completion edge, the block SHALL set Ready=1 for exactly one cycle and Busy=0, and return to IDLE.
REQ-019 With LATENCY=1, the completion edge SHALL be the acceptance edge plus one; Ready SHALL be high in the second cycle after Valid is sampled, and Busy SHALL be high for one cycle.
REQ-020 Valid, MemWrite, DataAdr and WriteDataBlock SHALL be ignored while Busy=1; there SHALL be no queuing.
REQ-021 A new request MAY be accepted in the cycle in which Ready=1, giving back-to-back throughput of one request per LATENCY+1 cycles.
REQ-022 ReadDataBlock SHALL hold its value until the next read completes; writes and reset SHALL NOT alter it except as stated in REQ-025.
REQ-023 A read of a block completed after a write to the same block SHALL return the written data; there SHALL be no bypass of in-flight writes, because accesses are serialised.
REQ-024 Storage SHALL initialise to all zeros at time zero, for simulation only.

Reset
REQ-025 On reset=1 at a clock edge, the block SHALL set: state to IDLE; counter to 0; Ready=0; Busy=0; ReadDataBlock=0.
REQ-026 Reset SHALL take priority over a simultaneous Valid or completion.
REQ-027 Reset SHALL abort an in-flight request: no storage write SHALL occur and no Ready pulse SHALL follow.
REQ-028 Reset SHALL NOT clear storage contents.

Structure
REQ-029 Package dram_pkg SHALL hold: the state enum (IDLE, WAIT); WORD_W=32; and default values for WORDS, ADDR_W and LATENCY.
REQ-030 Storage SHALL be a sub-module dram_array containing a word array, a WORDS-wide synchronous write port and a WORDS-wide registered read port.
REQ-031 The FSM, counter and request latches SHALL reside in dram_block_mem.

Verification
REQ-032 Defaults: write 0x11111111..0x44444444 to address 0x100, then read 0x100 -> Ready at acceptance+1; ReadDataBlock = {0x44444444, 0x33333333, 0x22222222, 0x11111111}.
REQ-033 Misaligned access with WORDS=4: write to address 0x103, then read 0x100 -> the same block is returned; words 0x104-0x107 remain 0.
REQ-034 LATENCY=5: a read is accepted at cycle 0 -> Busy is high in cycles 1-5; Ready is high only in cycle 5; Valid toggled in cycles 1-4 is ignored.
REQ-035 Reset mid-write: with LATENCY=4, a write is accepted and reset is asserted 2 cycles later -> Ready never pulses; a later read of that block returns its prior contents.
REQ-036 Wrap-around: with ADDR_W=20, write to 0x00100100, then read 0x00000100 -> the written data is returned.
REQ-037 Back-to-back: a new Valid in the Ready cycle is accepted -> Ready pulses every LATENCY+1 cycles across 8 requests.
